// File: rtl/ray_node_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ray_node_issuer
// Purpose  : Producer side of the ray/node traversal stream. Accepts one ray
//            command covering an inclusive node-index range, fetches every
//            node from BVH node memory (1-cycle read latency), emits one
//            ray+node packet per node on rayNodeOut, counts the in-order
//            intersect responses and returns a per-ray summary on done.
// Ports    : clock/reset       - clock, asynchronous active-low reset
//            io_cmd_*          - ray command (ready/valid)
//            io_nodeRd_*       - node memory read port (data valid cycle+1)
//            io_rayNodeOut_*   - ray+node packet stream (ready/valid)
//            io_hit_*          - in-order intersect responses (always taken)
//            io_done_*         - per-ray summary (ready/valid)
// Revision : 1.0 - initial release
// ============================================================================
module ray_node_issuer #(
  parameter int IDX_W = 11,
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  // command
  output logic             io_cmd_ready,
  input  logic             io_cmd_valid,
  input  logic [31:0]      io_cmd_bits_ray_origin_0,
  input  logic [31:0]      io_cmd_bits_ray_origin_1,
  input  logic [31:0]      io_cmd_bits_ray_origin_2,
  input  logic [31:0]      io_cmd_bits_ray_dir_0,
  input  logic [31:0]      io_cmd_bits_ray_dir_1,
  input  logic [31:0]      io_cmd_bits_ray_dir_2,
  input  logic [31:0]      io_cmd_bits_ray_dRcp_0,
  input  logic [31:0]      io_cmd_bits_ray_dRcp_1,
  input  logic [31:0]      io_cmd_bits_ray_dRcp_2,
  input  logic [31:0]      io_cmd_bits_ray_minT,
  input  logic [31:0]      io_cmd_bits_ray_maxT,
  input  logic [31:0]      io_cmd_bits_ray_id,
  input  logic [IDX_W-1:0] io_cmd_bits_firstIdx,
  input  logic [IDX_W-1:0] io_cmd_bits_lastIdx,
  // node memory
  output logic             io_nodeRd_en,
  output logic [IDX_W-1:0] io_nodeRd_addr,
  input  logic [63:0]      io_nodeRd_data,
  input  logic [31:0]      io_nodeRd_bbox_min_0,
  input  logic [31:0]      io_nodeRd_bbox_min_1,
  input  logic [31:0]      io_nodeRd_bbox_min_2,
  input  logic [31:0]      io_nodeRd_bbox_max_0,
  input  logic [31:0]      io_nodeRd_bbox_max_1,
  input  logic [31:0]      io_nodeRd_bbox_max_2,
  // ray+node packet stream
  input  logic             io_rayNodeOut_ready,
  output logic             io_rayNodeOut_valid,
  output logic [31:0]      io_rayNodeOut_bits_ray_origin_0,
  output logic [31:0]      io_rayNodeOut_bits_ray_origin_1,
  output logic [31:0]      io_rayNodeOut_bits_ray_origin_2,
  output logic [31:0]      io_rayNodeOut_bits_ray_dir_0,
  output logic [31:0]      io_rayNodeOut_bits_ray_dir_1,
  output logic [31:0]      io_rayNodeOut_bits_ray_dir_2,
  output logic [31:0]      io_rayNodeOut_bits_ray_dRcp_0,
  output logic [31:0]      io_rayNodeOut_bits_ray_dRcp_1,
  output logic [31:0]      io_rayNodeOut_bits_ray_dRcp_2,
  output logic [31:0]      io_rayNodeOut_bits_ray_minT,
  output logic [31:0]      io_rayNodeOut_bits_ray_maxT,
  output logic [31:0]      io_rayNodeOut_bits_ray_id,
  output logic [63:0]      io_rayNodeOut_bits_node_data,
  output logic [31:0]      io_rayNodeOut_bits_bbox_min_0,
  output logic [31:0]      io_rayNodeOut_bits_bbox_min_1,
  output logic [31:0]      io_rayNodeOut_bits_bbox_min_2,
  output logic [31:0]      io_rayNodeOut_bits_bbox_max_0,
  output logic [31:0]      io_rayNodeOut_bits_bbox_max_1,
  output logic [31:0]      io_rayNodeOut_bits_bbox_max_2,
  output logic [IDX_W-1:0] io_rayNodeOut_bits_nodeIdx,
  // intersect responses
  input  logic             io_hit_valid,
  input  logic             io_hit_intersect,
  // summary
  input  logic             io_done_ready,
  output logic             io_done_valid,
  output logic [31:0]      io_done_bits_rayId,
  output logic [CNT_W-1:0] io_done_bits_hitCount,
  output logic             io_done_bits_anyHit,
  output logic [IDX_W-1:0] io_done_bits_firstHitIdx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               init_q;
  logic [11:0][31:0]  ray_q;       // [0..2] origin, [3..5] dir, [6..8] dRcp, [9] minT, [10] maxT, [11] id
  logic [5:0][31:0]   bbox_q;      // [0..2] min, [3..5] max
  logic [63:0]        node_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   resp_q, resp_d;
  logic [IDX_W-1:0]   first_hit_q, first_hit_d;
  logic               found_q, found_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   outst_q, outst_d;

  logic [11:0][31:0]  cmd_ray;
  logic [5:0][31:0]   rd_bbox;
  logic               cmd_fire, out_fire, done_fire, hit_take;

  assign cmd_ray = {io_cmd_bits_ray_id, io_cmd_bits_ray_maxT, io_cmd_bits_ray_minT,
                    io_cmd_bits_ray_dRcp_2, io_cmd_bits_ray_dRcp_1, io_cmd_bits_ray_dRcp_0,
                    io_cmd_bits_ray_dir_2, io_cmd_bits_ray_dir_1, io_cmd_bits_ray_dir_0,
                    io_cmd_bits_ray_origin_2, io_cmd_bits_ray_origin_1, io_cmd_bits_ray_origin_0};
  assign rd_bbox = {io_nodeRd_bbox_max_2, io_nodeRd_bbox_max_1, io_nodeRd_bbox_max_0,
                    io_nodeRd_bbox_min_2, io_nodeRd_bbox_min_1, io_nodeRd_bbox_min_0};

  // cmd_ready is additionally gated by init_q so it reads 0 while reset is
  // asserted, even though the state register already sits in IDLE.
  assign io_cmd_ready        = init_q && (state_q == S_IDLE);
  assign io_nodeRd_en        = (state_q == S_FETCH);
  assign io_nodeRd_addr      = idx_q;
  assign io_rayNodeOut_valid = (state_q == S_ISSUE);
  assign io_done_valid       = (state_q == S_DONE);

  assign cmd_fire  = io_cmd_ready && io_cmd_valid;
  assign out_fire  = io_rayNodeOut_valid && io_rayNodeOut_ready;
  assign done_fire = io_done_valid && io_done_ready;
  // Responses with nothing outstanding (e.g. stale ones after a reset) are dropped.
  assign hit_take  = io_hit_valid && (outst_q != '0);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    resp_d      = resp_q;
    first_hit_d = first_hit_q;
    found_d     = found_q;
    hit_cnt_d   = hit_cnt_q;
    outst_d     = outst_q;

    if (hit_take) begin
      resp_d = resp_q + 1'b1;
      if (io_hit_intersect) begin
        hit_cnt_d = hit_cnt_q + 1'b1;
        if (!found_q) begin
          first_hit_d = resp_q;
          found_d     = 1'b1;
        end
      end
    end

    case ({out_fire, hit_take})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          idx_d       = io_cmd_bits_firstIdx;
          resp_d      = io_cmd_bits_firstIdx;
          hit_cnt_d   = '0;
          found_d     = 1'b0;
          first_hit_d = '1;
          state_d     = (io_cmd_bits_lastIdx < io_cmd_bits_firstIdx) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (out_fire) begin
          // Compare before incrementing so an all-ones lastIdx never wraps idx.
          if (idx_q == last_q) begin
            state_d = S_DRAIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (outst_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (done_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      init_q      <= 1'b0;
      ray_q       <= '0;
      bbox_q      <= '0;
      node_q      <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      resp_q      <= '0;
      first_hit_q <= '1;
      found_q     <= 1'b0;
      hit_cnt_q   <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      idx_q       <= idx_d;
      resp_q      <= resp_d;
      first_hit_q <= first_hit_d;
      found_q     <= found_d;
      hit_cnt_q   <= hit_cnt_d;
      outst_q     <= outst_d;
      if (cmd_fire) begin
        ray_q  <= cmd_ray;
        last_q <= io_cmd_bits_lastIdx;
      end
      // Read data is only valid in the cycle after the strobe.
      if (state_q == S_LOAD) begin
        node_q <= io_nodeRd_data;
        bbox_q <= rd_bbox;
      end
    end
  end

  assign io_rayNodeOut_bits_ray_origin_0 = ray_q[0];
  assign io_rayNodeOut_bits_ray_origin_1 = ray_q[1];
  assign io_rayNodeOut_bits_ray_origin_2 = ray_q[2];
  assign io_rayNodeOut_bits_ray_dir_0    = ray_q[3];
  assign io_rayNodeOut_bits_ray_dir_1    = ray_q[4];
  assign io_rayNodeOut_bits_ray_dir_2    = ray_q[5];
  assign io_rayNodeOut_bits_ray_dRcp_0   = ray_q[6];
  assign io_rayNodeOut_bits_ray_dRcp_1   = ray_q[7];
  assign io_rayNodeOut_bits_ray_dRcp_2   = ray_q[8];
  assign io_rayNodeOut_bits_ray_minT     = ray_q[9];
  assign io_rayNodeOut_bits_ray_maxT     = ray_q[10];
  assign io_rayNodeOut_bits_ray_id       = ray_q[11];
  assign io_rayNodeOut_bits_node_data    = node_q;
  assign io_rayNodeOut_bits_bbox_min_0   = bbox_q[0];
  assign io_rayNodeOut_bits_bbox_min_1   = bbox_q[1];
  assign io_rayNodeOut_bits_bbox_min_2   = bbox_q[2];
  assign io_rayNodeOut_bits_bbox_max_0   = bbox_q[3];
  assign io_rayNodeOut_bits_bbox_max_1   = bbox_q[4];
  assign io_rayNodeOut_bits_bbox_max_2   = bbox_q[5];
  assign io_rayNodeOut_bits_nodeIdx      = idx_q;

  assign io_done_bits_rayId       = ray_q[11];
  assign io_done_bits_hitCount    = hit_cnt_q;
  assign io_done_bits_anyHit      = (hit_cnt_q != '0);
  assign io_done_bits_firstHitIdx = first_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_ray_node_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ray_node_issuer
// Purpose  : Scoreboard bench for ray_node_issuer. Each command pushes its
//            expected fetch addresses, packets and summary into queues; the
//            negedge monitor pops and compares as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_node_issuer;
  localparam int IDX_W = 11;
  localparam int CNT_W = 12;

  typedef struct packed {
    logic [11:0][31:0] ray;
    logic [63:0]       data;
    logic [5:0][31:0]  bbox;
    logic [IDX_W-1:0]  idx;
  } pkt_t;

  typedef struct packed {
    logic [31:0]      id;
    logic [CNT_W-1:0] cnt;
    logic             any;
    logic [IDX_W-1:0] first;
  } done_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic              io_cmd_valid = 1'b0;
  logic [11:0][31:0] cmd_ray = '0;
  logic [IDX_W-1:0]  cmd_first = '0, cmd_last = '0;
  logic [63:0]       rd_data = '0;
  logic [5:0][31:0]  rd_bbox = '0;
  logic              rn_ready = 1'b1, done_ready = 1'b1;
  logic              hit_valid = 1'b0, hit_inter = 1'b0;

  wire               io_cmd_ready, io_nodeRd_en, io_rayNodeOut_valid, io_done_valid;
  wire [IDX_W-1:0]   io_nodeRd_addr, o_idx, o_first_hit;
  wire [11:0][31:0]  o_ray;
  wire [63:0]        o_data;
  wire [5:0][31:0]   o_bbox;
  wire [31:0]        o_ray_id;
  wire [CNT_W-1:0]   o_hit_cnt;
  wire               o_any;

  ray_node_issuer #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .io_cmd_ready(io_cmd_ready), .io_cmd_valid(io_cmd_valid),
    .io_cmd_bits_ray_origin_0(cmd_ray[0]), .io_cmd_bits_ray_origin_1(cmd_ray[1]),
    .io_cmd_bits_ray_origin_2(cmd_ray[2]), .io_cmd_bits_ray_dir_0(cmd_ray[3]),
    .io_cmd_bits_ray_dir_1(cmd_ray[4]), .io_cmd_bits_ray_dir_2(cmd_ray[5]),
    .io_cmd_bits_ray_dRcp_0(cmd_ray[6]), .io_cmd_bits_ray_dRcp_1(cmd_ray[7]),
    .io_cmd_bits_ray_dRcp_2(cmd_ray[8]), .io_cmd_bits_ray_minT(cmd_ray[9]),
    .io_cmd_bits_ray_maxT(cmd_ray[10]), .io_cmd_bits_ray_id(cmd_ray[11]),
    .io_cmd_bits_firstIdx(cmd_first), .io_cmd_bits_lastIdx(cmd_last),
    .io_nodeRd_en(io_nodeRd_en), .io_nodeRd_addr(io_nodeRd_addr), .io_nodeRd_data(rd_data),
    .io_nodeRd_bbox_min_0(rd_bbox[0]), .io_nodeRd_bbox_min_1(rd_bbox[1]),
    .io_nodeRd_bbox_min_2(rd_bbox[2]), .io_nodeRd_bbox_max_0(rd_bbox[3]),
    .io_nodeRd_bbox_max_1(rd_bbox[4]), .io_nodeRd_bbox_max_2(rd_bbox[5]),
    .io_rayNodeOut_ready(rn_ready), .io_rayNodeOut_valid(io_rayNodeOut_valid),
    .io_rayNodeOut_bits_ray_origin_0(o_ray[0]), .io_rayNodeOut_bits_ray_origin_1(o_ray[1]),
    .io_rayNodeOut_bits_ray_origin_2(o_ray[2]), .io_rayNodeOut_bits_ray_dir_0(o_ray[3]),
    .io_rayNodeOut_bits_ray_dir_1(o_ray[4]), .io_rayNodeOut_bits_ray_dir_2(o_ray[5]),
    .io_rayNodeOut_bits_ray_dRcp_0(o_ray[6]), .io_rayNodeOut_bits_ray_dRcp_1(o_ray[7]),
    .io_rayNodeOut_bits_ray_dRcp_2(o_ray[8]), .io_rayNodeOut_bits_ray_minT(o_ray[9]),
    .io_rayNodeOut_bits_ray_maxT(o_ray[10]), .io_rayNodeOut_bits_ray_id(o_ray[11]),
    .io_rayNodeOut_bits_node_data(o_data),
    .io_rayNodeOut_bits_bbox_min_0(o_bbox[0]), .io_rayNodeOut_bits_bbox_min_1(o_bbox[1]),
    .io_rayNodeOut_bits_bbox_min_2(o_bbox[2]), .io_rayNodeOut_bits_bbox_max_0(o_bbox[3]),
    .io_rayNodeOut_bits_bbox_max_1(o_bbox[4]), .io_rayNodeOut_bits_bbox_max_2(o_bbox[5]),
    .io_rayNodeOut_bits_nodeIdx(o_idx),
    .io_hit_valid(hit_valid), .io_hit_intersect(hit_inter),
    .io_done_ready(done_ready), .io_done_valid(io_done_valid),
    .io_done_bits_rayId(o_ray_id), .io_done_bits_hitCount(o_hit_cnt),
    .io_done_bits_anyHit(o_any), .io_done_bits_firstHitIdx(o_first_hit)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [IDX_W-1:0] q_fetch[$];
  pkt_t             q_pkt[$];
  done_t            q_done[$];
  bit               q_plan[$];   // response value per future packet, in order
  bit               q_pend[$];   // responses owed for packets already sent

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // traffic knobs set by the main sequence
  bit               rand_rdy = 0, rand_drdy = 0;
  int               bp_n = 0, dhold_n = 0, stray_n = 0;
  logic [IDX_W-1:0] bp_idx = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // node memory contents
  function automatic logic [63:0] mem_data(input logic [IDX_W-1:0] a);
    return {32'hC0DE_0000 | {21'd0, a}, 32'h0F0F_0000 ^ {21'd0, a}};
  endfunction
  function automatic logic [31:0] mem_bbox(input logic [IDX_W-1:0] a, input int k);
    return 32'h3F80_0000 + ({21'd0, a ^ 11'd5} << 4) + 32'(k);
  endfunction

  // memory: data for an address strobed in cycle N is valid in cycle N+1
  // only; any other cycle carries garbage.
  initial begin
    logic en_s;
    logic [IDX_W-1:0] a_s;
    forever begin
      @(negedge clock);
      en_s = io_nodeRd_en;
      a_s  = io_nodeRd_addr;
      @(posedge clock);
      #1;
      if (en_s) begin
        rd_data = mem_data(a_s);
        for (int k = 0; k < 6; k++) rd_bbox[k] = mem_bbox(a_s, k);
      end else begin
        rd_data = {$urandom, $urandom};
        for (int k = 0; k < 6; k++) rd_bbox[k] = $urandom;
      end
    end
  end

  // responder: in-order responses with random gaps, plus injected strays
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (stray_n > 0) begin
        hit_valid = 1'b1; hit_inter = 1'b1; stray_n--;
      end else if (q_pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        hit_valid = 1'b1; hit_inter = q_pend.pop_front();
      end else begin
        hit_valid = 1'b0; hit_inter = 1'($urandom_range(0, 1));
      end
    end
  end

  // ready drivers
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (bp_n > 0 && io_rayNodeOut_valid && o_idx == bp_idx) begin
        rn_ready = 1'b0; bp_n--;
      end else begin
        rn_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (dhold_n > 0 && io_done_valid) begin
        done_ready = 1'b0; dhold_n--;
      end else begin
        done_ready = rand_drdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // monitor
  initial begin
    pkt_t  cur, held, e;
    done_t dcur, dheld, de;
    bit    hold_v = 0, dhold_v = 0, rdy_next = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold_v = 0; dhold_v = 0; rdy_next = 0;
      end else begin
        if (io_nodeRd_en) begin
          if (q_fetch.size() == 0) chk("nodeRd_en_unexpected", 64'(io_nodeRd_addr), 64'h7FFF_FFFF);
          else chk("nodeRd_addr", 64'(io_nodeRd_addr), 64'(q_fetch.pop_front()));
        end

        cur = '{ray: o_ray, data: o_data, bbox: o_bbox, idx: o_idx};
        if (hold_v) begin
          chk("pkt_valid_held", 64'(io_rayNodeOut_valid), 64'd1);
          chk("pkt_bits_held", 64'(cur == held), 64'd1);
        end
        hold_v = 0;
        if (io_rayNodeOut_valid) begin
          if (rn_ready) begin
            if (q_pkt.size() == 0) begin
              chk("pkt_unexpected", 64'(o_idx), 64'h7FFF_FFFF);
            end else begin
              e = q_pkt.pop_front();
              chk("pkt_nodeIdx", 64'(cur.idx), 64'(e.idx));
              chk("pkt_node_data", cur.data, e.data);
              chk("pkt_bbox_min_0", 64'(cur.bbox[0]), 64'(e.bbox[0]));
              chk("pkt_bbox_all", 64'(cur.bbox == e.bbox), 64'd1);
              chk("pkt_ray", 64'(cur.ray == e.ray), 64'd1);
              if (q_plan.size() > 0) q_pend.push_back(q_plan.pop_front());
            end
          end else begin
            hold_v = 1; held = cur;
          end
        end

        if (rdy_next) chk("cmd_ready_after_done", 64'(io_cmd_ready), 64'd1);
        rdy_next = 0;
        dcur = '{id: o_ray_id, cnt: o_hit_cnt, any: o_any, first: o_first_hit};
        if (dhold_v) chk("done_bits_held", 64'(dcur == dheld), 64'd1);
        dhold_v = 0;
        if (io_done_valid) begin
          chk("cmd_ready_in_done", 64'(io_cmd_ready), 64'd0);
          if (done_ready) begin
            if (q_done.size() == 0) begin
              chk("done_unexpected", 64'(o_ray_id), 64'h7FFF_FFFF);
            end else begin
              de = q_done.pop_front();
              chk("done_rayId", 64'(dcur.id), 64'(de.id));
              chk("done_hitCount", 64'(dcur.cnt), 64'(de.cnt));
              chk("done_anyHit", 64'(dcur.any), 64'(de.any));
              chk("done_firstHitIdx", 64'(dcur.first), 64'(de.first));
            end
            done_seen++;
            rdy_next = 1;
          end else begin
            dhold_v = 1; dheld = dcur;
          end
        end
      end
    end
  end

  // Builds the expected traffic for one ray from the range and the planned
  // response bits (bit i = response for node firstIdx+i), then drives it.
  task automatic send_cmd(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l,
                          input logic [31:0] id, input logic [31:0] pat, input bit wait_done);
    logic [11:0][31:0] r;
    pkt_t  p;
    done_t d;
    int    t, seen0;
    for (int k = 0; k < 11; k++) r[k] = $urandom;
    r[11] = id;
    d = '{id: id, cnt: '0, any: 1'b0, first: '1};
    for (int i = int'(f); i <= int'(l); i++) begin
      bit h;
      h = pat[(i - int'(f)) % 32];
      q_fetch.push_back(IDX_W'(i));
      p.ray = r; p.data = mem_data(IDX_W'(i)); p.idx = IDX_W'(i);
      for (int k = 0; k < 6; k++) p.bbox[k] = mem_bbox(IDX_W'(i), k);
      q_pkt.push_back(p);
      q_plan.push_back(h);
      if (h) begin
        if (d.cnt == '0) d.first = IDX_W'(i);
        d.cnt = d.cnt + 1'b1;
      end
    end
    d.any = (d.cnt != '0);
    q_done.push_back(d);
    seen0 = done_seen;

    @(posedge clock);
    #1;
    io_cmd_valid = 1'b1; cmd_ray = r; cmd_first = f; cmd_last = l;
    t = 0;
    forever begin
      @(negedge clock);
      if (io_cmd_ready) break;
      t++;
      if (t > 500) begin
        chk("cmd_accept_timeout", 64'd0, 64'd1);
        io_cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clock);
    #1;
    io_cmd_valid = 1'b0;
    cmd_ray = {12{$urandom}}; cmd_first = IDX_W'($urandom); cmd_last = IDX_W'($urandom);
    if (l >= f) begin
      @(negedge clock); chk("latency_cycle1_valid", 64'(io_rayNodeOut_valid), 64'd0);
      @(negedge clock); chk("latency_cycle2_valid", 64'(io_rayNodeOut_valid), 64'd0);
      @(negedge clock); chk("latency_cycle3_valid", 64'(io_rayNodeOut_valid), 64'd1);
    end
    if (wait_done) begin
      t = 0;
      while (done_seen == seen0) begin
        @(negedge clock);
        t++;
        if (t > 3000) begin
          chk("done_timeout", 64'd0, 64'd1);
          break;
        end
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // reset state
    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", 64'(io_cmd_ready), 64'd0);
    chk("rst_nodeRd_en", 64'(io_nodeRd_en), 64'd0);
    chk("rst_pkt_valid", 64'(io_rayNodeOut_valid), 64'd0);
    chk("rst_done_valid", 64'(io_done_valid), 64'd0);
    chk("rst_hitCount", 64'(o_hit_cnt), 64'd0);
    chk("rst_firstHitIdx", 64'(o_first_hit), 64'h7FF);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single node, range with known responses, backpressure, empty range
    send_cmd(11'd5, 11'd5, 32'd7, 32'h1, 1);
    send_cmd(11'd2, 11'd6, 32'd21, 32'b10100, 1);
    bp_idx = 11'd3; bp_n = 4;
    send_cmd(11'd1, 11'd4, 32'd33, $urandom, 1);
    chk("bp_hold_consumed", 64'(bp_n), 64'd0);
    send_cmd(11'd9, 11'd8, 32'd44, 32'hFFFF_FFFF, 1);
    // held summary, then the top of the index space
    dhold_n = 3;
    send_cmd(11'd20, 11'd21, 32'd55, 32'b10, 1);
    send_cmd(11'h7FD, 11'h7FF, 32'd66, 32'b011, 1);

    // randomized rays with random backpressure and idle-time stray responses
    rand_rdy = 1; rand_drdy = 1;
    for (int n = 0; n < 25; n++) begin
      logic [IDX_W-1:0] f, l;
      int len;
      f   = IDX_W'($urandom_range(1, 2047));
      len = $urandom_range(0, 7);
      if (len == 0) l = f - 1'b1;
      else l = (int'(f) + len - 1 > 2047) ? 11'h7FF : IDX_W'(int'(f) + len - 1);
      send_cmd(f, l, $urandom, $urandom, 1);
      if ($urandom_range(0, 2) == 0) begin
        stray_n = 1;
        repeat (3) @(negedge clock);
      end
    end
    rand_rdy = 0; rand_drdy = 0;

    // reset while a packet is being presented
    bp_idx = 11'd12; bp_n = 1000;
    send_cmd(11'd10, 11'd14, 32'd77, $urandom, 0);
    t = 0;
    while (!(io_rayNodeOut_valid && o_idx == 11'd12) && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("reach_issue_node12", 64'(io_rayNodeOut_valid && o_idx == 11'd12), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_pkt_valid", 64'(io_rayNodeOut_valid), 64'd0);
    chk("midrst_nodeRd_en", 64'(io_nodeRd_en), 64'd0);
    chk("midrst_done_valid", 64'(io_done_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(io_cmd_ready), 64'd0);
    q_fetch.delete(); q_pkt.delete(); q_done.delete(); q_plan.delete(); q_pend.delete();
    bp_n = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    stray_n = 2;
    repeat (4) @(negedge clock);
    send_cmd(11'd5, 11'd5, 32'd7, 32'h1, 1);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
